rn_w_sched: RTL and testbench
=============================

// Module: rn_w_sched
// PURPOSE
//  Write-path scheduler for the RN wrapper. It records every accepted AW request as {id, len, tgtid} in an in-order table.
//  It gates CPU W beats onto the NoC W port only while an AW entry is pending, and stamps each beat with head, tail and the target node.
//  It sits between the CPU W channel and the NoC W injection port and replaces the ad-hoc WVALID-derived head/tail.
// PARAMETERS
//  DEPTH  4   outstanding AW entries; power of two, >=2
//  ID_W   11  AXI transaction ID width
//  TGT_W  2   NoC target node ID width
//  LEN_W  8   AXI burst length field width (beats-1)
// PORTS
//  clk        in   1              clock
//  rst        in   1              synchronous active-high reset
//  aw_fire    in   1              AW handshake done this cycle (AWVALID & AWREADY)
//  aw_id      in   ID_W           AWID of the accepted request
//  aw_len     in   LEN_W          AWLEN of the accepted request
//  aw_tgtid   in   TGT_W          SAM-decoded target of the accepted request
//  aw_block   out  1              table full; wrapper forces AWREADY low
//  s_wvalid   in   1              CPU WVALID
//  s_wready   out  1              CPU WREADY
//  s_wlast    in   1              CPU WLAST
//  m_w_valid  out  1              NoC w_valid
//  m_w_ready  in   1              NoC w_ready
//  m_w_head   out  1              first beat of burst
//  m_w_tail   out  1              last beat of burst
//  m_w_tgtid  out  TGT_W          NoC w_tgtid
//  cur_id     out  ID_W           ID of the burst currently draining
//  outstanding out $clog2(DEPTH+1) entries held, including the active burst
//  len_err    out  1              sticky WLAST/AWLEN mismatch flag
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (rst). It empties the table, zeroes beat_cnt, returns the FSM to IDLE and clears len_err.
//  - Output reset values: aw_block=0, s_wready=0, m_w_valid=0, m_w_head=0, m_w_tail=0, m_w_tgtid=0, cur_id=0, outstanding=0, len_err=0.
//  - Table: registered in-order FIFO. aw_fire pushes {aw_id, aw_len, aw_tgtid}. The pop is the W accept (w_acc) that carries the tail.
//  - aw_block = full, taken from registered occupancy. No push bypass: a same-cycle pop while full does not unblock that cycle.
//  - aw_fire while full is illegal. The entry is dropped and an assertion fires.
//  - Latency: a push in cycle N makes the entry visible at the table head in N+1. W cannot issue in the push cycle, even from empty.
//  - Gating, combinational: m_w_valid = s_wvalid & ~empty; s_wready = m_w_ready & ~empty.
//  - w_acc = m_w_valid & m_w_ready.
//  - m_w_tgtid and cur_id come from the head entry; both are 0 when empty.
//  - beat_cnt: LEN_W bits. It increments on w_acc and clears on a tail accept. It never wraps, because the tail occurs at cnt==len.
//  - m_w_head = ~empty & (beat_cnt==0).
//  - m_w_tail = ~empty & (beat_cnt==head.len). With len=0, head and tail are both 1 on a single beat.
//  - Tail is computed from AWLEN, not from s_wlast.
//  - FSM, 2 bits:
//      IDLE -> HEAD when table becomes non-empty.
//      HEAD -> BODY on a non-tail w_acc.
//      HEAD or BODY -> HEAD on a tail accept while another entry is pending.
//      HEAD or BODY -> IDLE on a tail accept when the table is then empty.
//  - Push and pop in the same cycle: occupancy is unchanged, and the new entry queues behind the old.
//  - outstanding updates on the cycle after a push or pop; push+pop gives a net 0 change.
//  - Reset during a burst discards all entries and the partial burst. The first beat after reset needs a fresh aw_fire.
// CONFIGURATION
//  - Macro RN_W_SCHED_LASTCHK_EN.
//  - Defined: on every w_acc, s_wlast != m_w_tail sets len_err, which stays set until rst. The beat is still forwarded and the table still pops on the computed tail.
//  - Undefined: no compare logic; len_err is tied to 0.
// STRUCTURE
//  - Package rn_noc_pkg holds:
//      TGT_W, ID_W and LEN_W constants;
//      typedef struct packed {id, len, tgtid} rn_wr_entry_t;
//      enum w_sched_state_e {IDLE, HEAD, BODY}.
//  - One sub-module: rn_sync_fifo #(type T, DEPTH), the generic registered FIFO with full, empty and count outputs.
//  - Beat counter, FSM, gating and the check stay in rn_w_sched.
// TESTING
//  1. Single beat: aw_fire(id=5, len=0, tgt=2), then s_wvalid=1 and s_wlast=1. Expect one beat with head=1, tail=1, tgtid=2; outstanding 1->0.
//  2. Burst: aw_fire(len=3, tgt=1), then 4 beats with m_w_ready toggling 1,0,1. Expect head only on beat 0, tail only on beat 3, and cnt holding during stalls.
//  3. Gating: s_wvalid=1 with the table empty. Expect m_w_valid=0 and s_wready=0. aw_fire at N gives m_w_valid=1 at N+1.
//  4. Full: DEPTH=4 and 4 aw_fire with no W. Expect aw_block=1. Pop one tail; aw_block=0 the next cycle.
//     Push and pop in the same cycle: outstanding is unchanged.
//  5. Order: aw(id=1, tgt=0, len=1) then aw(id=2, tgt=3, len=0). Expect beats tagged tgt 0,0 then 3, and cur_id 1 then 2.
//  6. With RN_W_SCHED_LASTCHK_EN: len=2 and s_wlast=1 on beat 1. Expect len_err=1 (sticky) and the pop still on beat 2.
//     rst mid-burst: all outputs at reset values the cycle after.

Source files
------------

// File: rtl/rn_noc_pkg.sv
// Shared NoC/RN write-path types: width constants, AW table entry, W scheduler FSM states.
package rn_noc_pkg;

  localparam int TGT_W = 2;
  localparam int ID_W  = 11;
  localparam int LEN_W = 8;

  // One accepted AW request as held in the in-order write table.
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
    logic [TGT_W-1:0] tgtid;
  } rn_wr_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } w_sched_state_e;

endpackage

// File: rtl/rn_sync_fifo.sv
// Generic registered FIFO. Push while full is dropped, pop while empty is ignored.
// Data written in cycle N is visible on dout in N+1; DEPTH must be a power of two.
module rn_sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  // Storage array; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers and occupancy; push+pop keeps the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rn_w_sched.sv
// RN write-path scheduler: queues accepted AW requests in order and gates CPU W beats
// onto the NoC W port, stamping head/tail from AWLEN and the target node from the head entry.
// Optional WLAST-vs-AWLEN check enabled by defining RN_W_SCHED_LASTCHK_EN.
module rn_w_sched
  import rn_noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = rn_noc_pkg::ID_W,
  parameter int TGT_W = rn_noc_pkg::TGT_W,
  parameter int LEN_W = rn_noc_pkg::LEN_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       aw_fire,
  input  logic [ID_W-1:0]            aw_id,
  input  logic [LEN_W-1:0]           aw_len,
  input  logic [TGT_W-1:0]           aw_tgtid,
  output logic                       aw_block,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  input  logic                       s_wlast,
  output logic                       m_w_valid,
  input  logic                       m_w_ready,
  output logic                       m_w_head,
  output logic                       m_w_tail,
  output logic [TGT_W-1:0]           m_w_tgtid,
  output logic [ID_W-1:0]            cur_id,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       len_err
);

  localparam int CW = $clog2(DEPTH + 1);

  rn_wr_entry_t   push_ent, hd;
  logic           full, empty, w_acc, pop, more;
  logic [CW-1:0]  count;
  logic [LEN_W-1:0] beat_cnt;
  w_sched_state_e state_q, state_d;

  assign push_ent = '{id: aw_id, len: aw_len, tgtid: aw_tgtid};

  rn_sync_fifo #(.T(rn_wr_entry_t), .DEPTH(DEPTH)) u_tbl (
    .clk   (clk),
    .rst   (rst),
    .push  (aw_fire),
    .din   (push_ent),
    .pop   (pop),
    .dout  (hd),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Gating and beat stamping, all from registered table state.
  assign aw_block    = full;
  assign outstanding = count;
  assign m_w_valid   = s_wvalid & ~empty;
  assign s_wready    = m_w_ready & ~empty;
  assign w_acc       = m_w_valid & m_w_ready;
  assign m_w_head    = ~empty & (beat_cnt == '0);
  assign m_w_tail    = ~empty & (beat_cnt == hd.len);
  assign m_w_tgtid   = empty ? '0 : hd.tgtid;
  assign cur_id      = empty ? '0 : hd.id;
  assign pop         = w_acc & m_w_tail;
  // Another burst is queued once the current tail pops.
  assign more        = (count > CW'(1)) | aw_fire;

  // Beat position within the active burst; tail resets it, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst)        beat_cnt <= '0;
    else if (w_acc) beat_cnt <= m_w_tail ? '0 : beat_cnt + LEN_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: tracks idle / first beat / mid-burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!empty) state_d = HEAD;
      HEAD: if (w_acc) state_d = m_w_tail ? (more ? HEAD : IDLE) : BODY;
      BODY: if (pop)   state_d = more ? HEAD : IDLE;
      default:         state_d = IDLE;
    endcase
  end

`ifdef RN_W_SCHED_LASTCHK_EN
  // Sticky flag when CPU WLAST disagrees with the AWLEN-derived tail.
  always_ff @(posedge clk) begin
    if (rst)                                len_err <= 1'b0;
    else if (w_acc && (s_wlast != m_w_tail)) len_err <= 1'b1;
  end
`else
  logic unused_wlast;
  assign unused_wlast = s_wlast;
  assign len_err      = 1'b0;
`endif

  // A push while full would be silently dropped by the table.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(aw_fire && full));

endmodule

// File: tb/tb_rn_w_sched.sv
// Randomized + directed bench for rn_w_sched against a queue-based burst model.
module tb_rn_w_sched;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, aw_fire, aw_block, s_wvalid, s_wready, s_wlast;
  logic        m_w_valid, m_w_ready, m_w_head, m_w_tail, len_err;
  logic [10:0] aw_id, cur_id;
  logic [7:0]  aw_len;
  logic [1:0]  aw_tgtid, m_w_tgtid;
  logic [2:0]  outstanding;

  always #5 clk = ~clk;

  rn_w_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .aw_fire(aw_fire), .aw_id(aw_id), .aw_len(aw_len),
    .aw_tgtid(aw_tgtid), .aw_block(aw_block), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_wlast(s_wlast), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_head(m_w_head),
    .m_w_tail(m_w_tail), .m_w_tgtid(m_w_tgtid), .cur_id(cur_id),
    .outstanding(outstanding), .len_err(len_err)
  );

  // Model: pending bursts in order, beat index into the head burst, sticky error.
  typedef struct { int id; int len; int tgt; } ent_t;
  ent_t q[$];
  int   bidx;
  bit   err;
  int   n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance the model.
  task automatic step(input bit r, input bit f, input int id, input int len, input int tgt,
                      input bit wv, input bit wl, input bit wr);
    bit emp, hd, tl, acc;
    rst = r; aw_fire = f; aw_id = 11'(id); aw_len = 8'(len); aw_tgtid = 2'(tgt);
    s_wvalid = wv; s_wlast = wl; m_w_ready = wr;
    #1;
    emp = (q.size() == 0);
    hd  = !emp && bidx == 0;
    tl  = !emp && bidx == q[0].len;
    chk("aw_block",    32'(aw_block),    32'(q.size() == DEPTH));
    chk("outstanding", 32'(outstanding), 32'(q.size()));
    chk("m_w_valid",   32'(m_w_valid),   32'(wv && !emp));
    chk("s_wready",    32'(s_wready),    32'(wr && !emp));
    chk("m_w_head",    32'(m_w_head),    32'(hd));
    chk("m_w_tail",    32'(m_w_tail),    32'(tl));
    chk("m_w_tgtid",   32'(m_w_tgtid),   emp ? 32'd0 : 32'(q[0].tgt));
    chk("cur_id",      32'(cur_id),      emp ? 32'd0 : 32'(q[0].id));
    chk("len_err",     32'(len_err),     32'(err));
    acc = wv && wr && !emp;
    if (r) begin
      q.delete(); bidx = 0; err = 0;
    end else begin
`ifdef RN_W_SCHED_LASTCHK_EN
      if (acc && (wl != tl)) err = 1;
`endif
      if (acc) begin
        if (tl) begin void'(q.pop_front()); bidx = 0; end
        else bidx++;
      end
      if (f) q.push_back('{id: id & 32'h7ff, len: len & 32'hff, tgt: tgt & 3});
    end
    @(posedge clk); #1;
  endtask

  // Idle cycle helper: no AW, no W.
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Correct WLAST for the next beat according to the model.
  function automatic bit good_last();
    return q.size() > 0 && bidx == q[0].len;
  endfunction

  initial begin
    n_vec = 0; n_err = 0; bidx = 0; err = 0;
    rst = 1; aw_fire = 0; aw_id = 0; aw_len = 0; aw_tgtid = 0;
    s_wvalid = 0; s_wlast = 0; m_w_ready = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, and gating with an empty table.
    step(0, 0, 0, 0, 0, 1, 1, 1);
    // Single beat burst: push, then head+tail beat.
    step(0, 1, 5, 0, 2, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1, 1);
    idle();
    // Four-beat burst with ready toggling.
    step(0, 1, 9, 3, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, good_last(), i[0] == 1'b0);
    idle();
    // Fill the table, then pop one tail, then push+pop same cycle.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 20 + i, 0, i, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 1, 1, 1);
    step(0, 1, 30, 0, 3, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 0, 1, 1, 1);
    // Order: two bursts back to back.
    step(0, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 2, 0, 3, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, good_last(), 1);
    // Early WLAST on a 3-beat burst, then reset mid-burst.
    step(0, 1, 7, 2, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1, 1);
    step(0, 1, 8, 3, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1, 1);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      bit f, wv, wr, wl, r;
      r  = ($urandom_range(0, 149) == 0);
      f  = (q.size() < DEPTH) && ($urandom_range(0, 2) == 0);
      wv = ($urandom_range(0, 9) < 7);
      wr = ($urandom_range(0, 9) < 7);
      wl = good_last() ^ ($urandom_range(0, 15) == 0);
      step(r, f, int'($urandom_range(0, 2047)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), wv, wl, wr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
